// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, FSM states,
// reservation-buffer entry layout.
package ifu_fetch_pkg;

  localparam int PC_W      = 64;
  localparam int INST_W    = 32;
  localparam int DEF_DEPTH = 4;

  // Canonical RISC-V NOP (addi x0, x0, 0) for decode-side bubble insertion.
  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              filled;
  } resv_entry_t;

endpackage

// File: rtl/ifu_fetch_if.sv
// Bundle of PC-stage, instruction-memory and decode-side signals around the
// fetch stage. master = the fetch stage, slave = its surroundings.
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  logic [PC_W-1:0]   pc_i;
  logic              fetch_en;
  logic              flush;
  logic              imem_req_valid;
  logic [PC_W-1:0]   imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              id_ready;
  logic              if_valid;
  logic [PC_W-1:0]   if_pc;
  logic [INST_W-1:0] if_inst;
  logic              fetch_stall;
  logic              rsp_err;

  modport master (
    input  pc_i, fetch_en, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst, fetch_stall, rsp_err
  );

  modport slave (
    output pc_i, fetch_en, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst, fetch_stall, rsp_err
  );

endinterface

// File: rtl/ifu_resv_buf.sv
// Circular reservation buffer. Entries are allocated in request order, filled
// in the same order by responses, and popped from the head once filled.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module ifu_resv_buf import ifu_fetch_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_alloc,
  input  logic [PC_W-1:0]          i_alloc_pc,
  input  logic                     i_fill,
  input  logic [INST_W-1:0]        i_fill_inst,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_has_unfilled,
  output logic [$clog2(DEPTH):0]   o_unfilled_cnt,
  output logic                     o_head_valid,
  output logic [PC_W-1:0]          o_head_pc,
  output logic [INST_W-1:0]        o_head_inst
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  resv_entry_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_alloc;
  logic [PTR_W-1:0] r_fill;

  logic [IDX_W-1:0] w_head_idx;
  logic [IDX_W-1:0] w_alloc_idx;
  logic [IDX_W-1:0] w_fill_idx;
  logic [PTR_W-1:0] w_count;

  assign w_head_idx  = r_head[IDX_W-1:0];
  assign w_alloc_idx = r_alloc[IDX_W-1:0];
  assign w_fill_idx  = r_fill[IDX_W-1:0];

  // Occupancy is taken before this cycle's pop, so a freed slot is reusable only next cycle.
  assign w_count        = r_alloc - r_head;
  assign o_full         = (w_count == PTR_W'(DEPTH));
  assign o_unfilled_cnt = r_alloc - r_fill;
  assign o_has_unfilled = (r_alloc != r_fill);
  assign o_head_valid   = (r_alloc != r_head) & r_mem[w_head_idx].filled;
  assign o_head_pc      = r_mem[w_head_idx].pc;
  assign o_head_inst    = r_mem[w_head_idx].inst;

  // Pointer and entry update: clear wins, otherwise alloc/fill/pop act independently.
  // NOTE: every sequential assignment is non-blocking so all three ports see
  // the pre-edge pointers, which is what makes same-cycle alloc+fill+pop safe.
  // NOTE: the storage is reset (not left uninitialised) because if_pc/if_inst
  // are read straight from the head entry and must be 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_alloc <= '0;
      r_fill  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      r_head  <= '0;
      r_alloc <= '0;
      r_fill  <= '0;
    end else begin
      if (i_alloc) begin
        r_mem[w_alloc_idx] <= '{pc: i_alloc_pc, inst: '0, filled: 1'b0};
        r_alloc            <= r_alloc + 1'b1;
      end
      if (i_fill) begin
        r_mem[w_fill_idx].inst   <= i_fill_inst;
        r_mem[w_fill_idx].filled <= 1'b1;
        r_fill                   <= r_fill + 1'b1;
      end
      if (i_pop) r_head <= r_head + 1'b1;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: issues pc_i to instruction memory, tracks in-flight
// fetches in a reservation buffer and hands instructions to decode in order.
// After a flush, responses to requests already in flight are counted off
// before new requests are issued.
module ifu_fetch import ifu_fetch_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH
) (
  input logic          clk,
  input logic          rst,
  ifu_fetch_if.master  bus
);

  localparam int PTR_W = $clog2(DEPTH) + 1;

  fetch_state_e     r_state;
  logic [PTR_W-1:0] r_discard_cnt;
  logic             r_rsp_err;

  logic             w_run;
  logic             w_full;
  logic             w_has_unfilled;
  logic [PTR_W-1:0] w_unfilled_cnt;
  logic             w_head_valid;
  logic [PC_W-1:0]  w_head_pc;
  logic [INST_W-1:0] w_head_inst;
  logic             w_req_valid;
  logic             w_req_fire;
  logic             w_fill;
  logic             w_if_valid;
  logic             w_pop;
  logic             w_rsp_unexpected;
  logic             w_rsp_matched;
  logic [PTR_W-1:0] w_discard_next;

  assign w_run = (r_state == RUN);

  // Issue is masked by flush and by a full buffer; flush also wins over pop.
  assign w_req_valid = w_run & bus.fetch_en & ~w_full & ~bus.flush;
  assign w_req_fire  = w_req_valid & bus.imem_req_ready;
  assign w_if_valid  = w_head_valid & ~bus.flush;
  assign w_pop       = w_if_valid & bus.id_ready;

  // A response in RUN always matches the oldest unfilled entry, if one exists.
  assign w_rsp_matched    = w_run & bus.imem_rsp_valid & w_has_unfilled;
  assign w_fill           = w_rsp_matched & ~bus.flush;
  assign w_rsp_unexpected = bus.imem_rsp_valid & ((r_state == IDLE) | (w_run & ~w_has_unfilled));

  // Responses still owed after a flush; one arriving in the flush cycle is already paid.
  assign w_discard_next = w_unfilled_cnt - PTR_W'(w_rsp_matched);

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = bus.pc_i;
  assign bus.fetch_stall    = bus.fetch_en & ~w_req_fire;
  assign bus.if_valid       = w_if_valid;
  assign bus.if_pc          = w_head_pc;
  assign bus.if_inst        = w_head_inst;
  assign bus.rsp_err        = r_rsp_err;

  ifu_resv_buf #(.DEPTH(DEPTH)) u_buf (
    .clk            (clk),
    .rst            (rst),
    .i_clear        (w_run & bus.flush),
    .i_alloc        (w_req_fire),
    .i_alloc_pc     (bus.pc_i),
    .i_fill         (w_fill),
    .i_fill_inst    (bus.imem_rsp_data),
    .i_pop          (w_pop),
    .o_full         (w_full),
    .o_has_unfilled (w_has_unfilled),
    .o_unfilled_cnt (w_unfilled_cnt),
    .o_head_valid   (w_head_valid),
    .o_head_pc      (w_head_pc),
    .o_head_inst    (w_head_inst)
  );

  // Fetch FSM: leave IDLE after reset, enter DRAIN on a flush with responses owed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_discard_cnt <= '0;
      r_rsp_err     <= 1'b0;
    end else begin
      if (w_rsp_unexpected) r_rsp_err <= 1'b1;
      case (r_state)
        IDLE: r_state <= RUN;
        RUN: begin
          if (bus.flush) begin
            r_discard_cnt <= w_discard_next;
            if (w_discard_next != '0) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.imem_rsp_valid) begin
            r_discard_cnt <= r_discard_cnt - 1'b1;
            if (r_discard_cnt == PTR_W'(1)) r_state <= RUN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a combinational vector table, directed
// multi-cycle sequences and a randomized run, all compared every cycle against
// a queue-based reference model of the fetch stage.
`timescale 1ns/1ps
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  localparam int TB_DEPTH = 4;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    bit                filled;
  } ment_t;

  typedef struct {
    bit fe;
    bit rr;
    bit fl;
    bit e_rv;
    bit e_stall;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ifu_fetch_if bus();

  ifu_fetch #(.DEPTH(TB_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: in-order queue of outstanding fetches plus drain bookkeeping.
  ment_t           mq[$];
  bit              m_started;
  bit              m_drain;
  bit              m_err;
  int              m_disc;
  // Instruction memory: addresses accepted but not yet answered.
  logic [PC_W-1:0] mem_q[$];

  bit              s_acc;
  bit              s_stall;
  bit              s_ifv;
  logic [PC_W-1:0] s_ifpc;

  vec_t            vecs[8];
  logic [PC_W-1:0] got_pc[$];
  int              got_cyc[$];

  function automatic logic [INST_W-1:0] inst_of(input logic [PC_W-1:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [PC_W-1:0] act, input logic [PC_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mem_q.delete();
    m_started = 1'b0;
    m_drain   = 1'b0;
    m_err     = 1'b0;
    m_disc    = 0;
  endtask

  task automatic idle_inputs();
    bus.pc_i           = '0;
    bus.fetch_en       = 1'b0;
    bus.flush          = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.id_ready       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    #1;
    check("rst_if_valid", bus.if_valid, 0);
    check("rst_req_valid", bus.imem_req_valid, 0);
    check("rst_fetch_stall", bus.fetch_stall, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_if_pc", bus.if_pc, 0);
    check("rst_if_inst", bus.if_inst, 0);
    rst = 1'b0;
    @(posedge clk);
    m_started = 1'b1;  // first edge out of reset moves the stage into RUN
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance both.
  // rsp_mode: 0 no response, 1 respond if memory owes one, 2 respond unconditionally.
  task automatic cycle(input bit fe, input logic [PC_W-1:0] pc, input bit rr,
                       input int rsp_mode, input bit fl, input bit idr);
    bit                rv;
    logic [INST_W-1:0] rd;
    bit                e_rv;
    bit                e_stall;
    bit                e_ifv;
    bit                found;
    int                u;
    @(negedge clk);
    rv = (rsp_mode == 2) || (rsp_mode == 1 && mem_q.size() > 0);
    rd = (mem_q.size() > 0) ? inst_of(mem_q[0]) : 32'hDEAD_BEEF;
    bus.fetch_en       = fe;
    bus.pc_i           = pc;
    bus.imem_req_ready = rr;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rd;
    bus.flush          = fl;
    bus.id_ready       = idr;
    #1;
    e_rv    = m_started && !m_drain && fe && (mq.size() < TB_DEPTH) && !fl;
    e_stall = fe && !(e_rv && rr);
    e_ifv   = (mq.size() > 0) && mq[0].filled && !fl;
    check("req_valid", bus.imem_req_valid, e_rv);
    check("fetch_stall", bus.fetch_stall, e_stall);
    check("if_valid", bus.if_valid, e_ifv);
    check("rsp_err", bus.rsp_err, m_err);
    if (e_rv) check("req_addr", bus.imem_req_addr, pc);
    if (e_ifv) begin
      check("if_pc", bus.if_pc, mq[0].pc);
      check("if_inst", bus.if_inst, mq[0].inst);
    end
    s_acc   = bus.imem_req_valid && rr;
    s_stall = bus.fetch_stall;
    s_ifv   = bus.if_valid;
    s_ifpc  = bus.if_pc;
    @(posedge clk);
    if (rv && mem_q.size() > 0) void'(mem_q.pop_front());
    if (s_acc) mem_q.push_back(pc);
    if (!m_started) begin
      m_started = 1'b1;
      if (rv) m_err = 1'b1;
    end else if (m_drain) begin
      if (rv) begin
        m_disc--;
        if (m_disc == 0) m_drain = 1'b0;
      end
    end else if (fl) begin
      u = 0;
      foreach (mq[i]) if (!mq[i].filled) u++;
      u -= int'(rv);
      if (u < 0) begin
        m_err = 1'b1;
        u = 0;
      end
      mq.delete();
      m_disc  = u;
      m_drain = (u > 0);
    end else begin
      if (rv) begin
        found = 1'b0;
        foreach (mq[i]) begin
          if (!found && !mq[i].filled) begin
            mq[i].inst   = rd;
            mq[i].filled = 1'b1;
            found        = 1'b1;
          end
        end
        if (!found) m_err = 1'b1;
      end
      if (e_ifv && idr) void'(mq.pop_front());
      if (e_rv && rr) mq.push_back('{pc: pc, inst: '0, filled: 1'b0});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [PC_W-1:0] pc;
    int              acc;
    bit              fe;
    bit              fl;

    idle_inputs();

    // Combinational issue/stall table in RUN with an empty buffer.
    vecs[0] = '{fe: 0, rr: 0, fl: 0, e_rv: 0, e_stall: 0};
    vecs[1] = '{fe: 0, rr: 0, fl: 1, e_rv: 0, e_stall: 0};
    vecs[2] = '{fe: 0, rr: 1, fl: 0, e_rv: 0, e_stall: 0};
    vecs[3] = '{fe: 0, rr: 1, fl: 1, e_rv: 0, e_stall: 0};
    vecs[4] = '{fe: 1, rr: 0, fl: 0, e_rv: 1, e_stall: 1};
    vecs[5] = '{fe: 1, rr: 0, fl: 1, e_rv: 0, e_stall: 1};
    vecs[6] = '{fe: 1, rr: 1, fl: 0, e_rv: 1, e_stall: 0};
    vecs[7] = '{fe: 1, rr: 1, fl: 1, e_rv: 0, e_stall: 1};
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.fetch_en       = vecs[i].fe;
      bus.imem_req_ready = vecs[i].rr;
      bus.flush          = vecs[i].fl;
      bus.pc_i           = 64'h8000_0000 + 64'(i * 4);
      #1;
      check($sformatf("vec%0d_req_valid", i), bus.imem_req_valid, vecs[i].e_rv);
      check($sformatf("vec%0d_stall", i), bus.fetch_stall, vecs[i].e_stall);
    end
    idle_inputs();

    // 1: streaming, memory always ready, one-cycle responses.
    do_reset();
    got_pc.delete();
    got_cyc.delete();
    for (int k = 0; k < 8; k++) begin
      cycle(k < 3, 64'h8000_0000 + 64'(4 * k), 1'b1, 1, 1'b0, 1'b1);
      check("s1_no_stall", s_stall, 0);
      if (s_ifv) begin
        got_pc.push_back(s_ifpc);
        got_cyc.push_back(k);
      end
    end
    check("s1_count", got_pc.size(), 3);
    if (got_cyc.size() > 0) check("s1_first_cycle", got_cyc[0], 2);
    for (int i = 0; i < got_pc.size(); i++) begin
      check("s1_order", got_pc[i], 64'h8000_0000 + 64'(4 * i));
      if (i > 0) check("s1_no_gap", got_cyc[i], got_cyc[i-1] + 1);
    end

    // 2: decode stalled, five PCs offered to a four-entry buffer.
    do_reset();
    pc  = 64'h8000_1000;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, pc, 1'b1, 1, 1'b0, 1'b0);
      if (s_acc) begin
        acc++;
        pc += 4;
      end
    end
    check("s2_accepted", acc, 4);
    check("s2_fifth_stalled", s_stall, 1);
    cycle(1'b1, pc, 1'b1, 1, 1'b0, 1'b1);
    check("s2_stall_in_release_cycle", s_stall, 1);
    cycle(1'b1, pc, 1'b1, 1, 1'b0, 1'b1);
    check("s2_fifth_accepted", s_acc, 1);
    for (int k = 0; k < 8; k++) cycle(1'b0, pc + 4, 1'b1, 1, 1'b0, 1'b1);

    // 3: flush with three outstanding and no same-cycle response.
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b1, 64'h8000_2000 + 64'(4 * k), 1'b1, 0, 1'b0, 1'b1);
    cycle(1'b1, 64'h8000_0100, 1'b1, 0, 1'b1, 1'b1);
    check("s3_flush_if_valid", s_ifv, 0);
    for (int d = 0; d < 3; d++) begin
      cycle(1'b1, 64'h8000_0100, 1'b1, 1, 1'b0, 1'b1);
      check("s3_drain_stall", s_stall, 1);
      check("s3_drain_if_valid", s_ifv, 0);
    end
    cycle(1'b1, 64'h8000_0100, 1'b1, 0, 1'b0, 1'b1);
    check("s3_reissue", s_acc, 1);
    cycle(1'b0, 64'h8000_0104, 1'b1, 1, 1'b0, 1'b1);
    cycle(1'b0, 64'h8000_0104, 1'b1, 0, 1'b0, 1'b1);
    check("s3_first_valid", s_ifv, 1);
    check("s3_first_pc", s_ifpc, 64'h8000_0100);

    // 4: flush coincident with a response while two are outstanding.
    do_reset();
    for (int k = 0; k < 2; k++) cycle(1'b1, 64'h8000_3000 + 64'(4 * k), 1'b1, 0, 1'b0, 1'b1);
    cycle(1'b1, 64'h8000_0200, 1'b1, 1, 1'b1, 1'b1);
    check("s4_flush_if_valid", s_ifv, 0);
    cycle(1'b1, 64'h8000_0200, 1'b1, 0, 1'b0, 1'b1);
    check("s4_still_draining", s_stall, 1);
    cycle(1'b1, 64'h8000_0200, 1'b1, 1, 1'b0, 1'b1);
    check("s4_last_discard_stall", s_stall, 1);
    check("s4_no_stale_valid", s_ifv, 0);
    cycle(1'b1, 64'h8000_0200, 1'b1, 0, 1'b0, 1'b1);
    check("s4_back_in_run", s_acc, 1);
    for (int k = 0; k < 4; k++) cycle(1'b0, 64'h8000_0204, 1'b1, 1, 1'b0, 1'b1);

    // 5: response with nothing outstanding sets a sticky error.
    do_reset();
    cycle(1'b0, '0, 1'b1, 2, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, '0, 1'b1, 0, 1'b0, 1'b1);
      check("s5_err_sticky", bus.rsp_err, 1);
      check("s5_no_valid", s_ifv, 0);
    end

    // 6: asynchronous reset with two filled entries waiting for decode.
    do_reset();
    cycle(1'b1, 64'h8000_4000, 1'b1, 0, 1'b0, 1'b0);
    cycle(1'b1, 64'h8000_4004, 1'b1, 1, 1'b0, 1'b0);
    cycle(1'b0, 64'h8000_4008, 1'b1, 1, 1'b0, 1'b0);
    cycle(1'b0, 64'h8000_4008, 1'b1, 0, 1'b0, 1'b0);
    check("s6_valid_before_rst", s_ifv, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("s6_async_if_valid", bus.if_valid, 0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    m_started = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, '0, 1'b1, 0, 1'b0, 1'b1);
      check("s6_empty_after_rst", s_ifv, 0);
    end

    // Randomized traffic against the model.
    do_reset();
    pc = 64'h8000_0000;
    for (int k = 0; k < 3000; k++) begin
      fe = ($urandom_range(0, 9) < 8);
      fl = ($urandom_range(0, 19) == 0);
      if (fl) pc = {32'h0, 32'h8000_0000 | ($urandom & 32'h000F_FFFC)};
      cycle(fe, pc, $urandom_range(0, 9) < 7, ($urandom_range(0, 1) == 1) ? 1 : 0,
            fl, $urandom_range(0, 9) < 6);
      if (!fl && fe && !s_stall) pc += 4;
    end
    for (int k = 0; k < 30; k++) cycle(1'b0, pc, 1'b1, 1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
